// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit
//   Condition unit placed directly after the ALU. It holds the architectural
//   NZCV flags register and evaluates the instruction condition field against
//   it. It gates the decoder's PC, register-file and memory write enables, and
//   registers the ALU result for the writeback/memory-address path. The
//   ALUOut stage has stall and flush control.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   Cond        in   4-bit instruction condition field
//   ALUFlags    in   {N,Z,C,V} from the ALU
//   ALUResult   in   ALU result, WIDTH bits
//   FlagW       in   [1] update N,Z  /  [0] update C,V
//   PCS         in   decoder: instruction writes PC
//   RegW        in   decoder: instruction writes register file
//   MemW        in   decoder: instruction writes memory
//   NoWrite     in   compare-type op, suppresses RegWrite
//   Stall       in   hold all state this cycle
//   Flush       in   invalidate the ALUOut stage
//   CondEx      out  condition passed (combinational from Cond and Flags)
//   PCSrc       out  PCS & CondEx
//   RegWrite    out  RegW & CondEx & ~NoWrite
//   MemWrite    out  MemW & CondEx
//   Flags       out  current NZCV register
//   ALUOut      out  registered ALU result
//   ALUOutValid out  ALUOut holds a condition-passed result
// ---------------------------------------------------------------------------
module cond_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             Stall,
    input  logic             Flush,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] ALUOut,
    output logic             ALUOutValid
);

    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             alu_vld_q, alu_vld_d;
    logic             cond_ex;
    logic             n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Condition decode uses only the registered flags, never same-cycle
    // ALUFlags, so the flag update lands at the edge between a flag-setting
    // op and the conditional op that follows it.
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;   // AL and 1111 always pass
        endcase
    end

    // N,Z and C,V halves update independently; a failed condition or a
    // stall leaves the whole register untouched.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && !Stall) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Flush outranks Stall: it drops the valid bit but keeps the data.
    always_comb begin
        alu_out_d = alu_out_q;
        alu_vld_d = alu_vld_q;
        if (Flush) begin
            alu_vld_d = 1'b0;
        end else if (!Stall) begin
            alu_out_d = ALUResult;
            alu_vld_d = cond_ex;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= FLAGS_RESET;
            alu_out_q <= '0;
            alu_vld_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            alu_out_q <= alu_out_d;
            alu_vld_q <= alu_vld_d;
        end
    end

    assign CondEx      = cond_ex;
    assign PCSrc       = PCS & cond_ex;
    assign RegWrite    = RegW & cond_ex & ~NoWrite;
    assign MemWrite    = MemW & cond_ex;
    assign Flags       = flags_q;
    assign ALUOut      = alu_out_q;
    assign ALUOutValid = alu_vld_q;

endmodule

// File: tb/tb_cond_unit.sv
`timescale 1ns/1ps
// Directed testbench for cond_unit.
module tb_cond_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [31:0] ALUResult;
    logic [1:0]  FlagW;
    logic        PCS, RegW, MemW, NoWrite, Stall, Flush;
    logic        CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic [31:0] ALUOut;
    logic        ALUOutValid;

    int checks = 0;
    int errors = 0;

    cond_unit #(.WIDTH(32), .FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .ALUResult(ALUResult), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall), .Flush(Flush),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Flags(Flags), .ALUOut(ALUOut),
        .ALUOutValid(ALUOutValid)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference condition evaluation: base test on Cond[3:1], inverted by Cond[0].
    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, b;
        {n, z, c, v} = f;
        b = 1'b0;
        case (cc[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b0;
        endcase
        return (cc[3:1] == 3'd7) ? 1'b1 : (b ^ cc[0]);
    endfunction

    initial begin
        reset = 1'b1; Cond = 4'b1110; ALUFlags = 4'b0000; ALUResult = 32'h0;
        FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        Stall = 1'b0; Flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_flags", {28'h0, Flags}, 32'h0);
        check("rst_aluout", ALUOut, 32'h0);
        check("rst_valid", {31'h0, ALUOutValid}, 32'h0);
        Cond = 4'b0000; #1;
        check("rst_eq", {31'h0, CondEx}, 32'h0);
        Cond = 4'b1110; #1;
        check("rst_al", {31'h0, CondEx}, 32'h1);

        // Flag set: SUB 5-5
        ALUFlags = 4'b0110; FlagW = 2'b11; Cond = 4'b1110;
        tick;
        FlagW = 2'b00;
        check("set_flags", {28'h0, Flags}, 32'h6);
        check("set_valid", {31'h0, ALUOutValid}, 32'h1);
        Cond = 4'b0000; #1;
        check("set_eq", {31'h0, CondEx}, 32'h1);
        Cond = 4'b1000; #1;
        check("set_hi", {31'h0, CondEx}, 32'h0);

        // Split writes
        Cond = 4'b1110; ALUFlags = 4'b1001; FlagW = 2'b10;
        tick;
        check("split_nz", {28'h0, Flags}, 32'hA);
        ALUFlags = 4'b0001; FlagW = 2'b01;
        tick;
        FlagW = 2'b00;
        check("split_cv", {28'h0, Flags}, 32'h9);
        Cond = 4'b1010; #1;
        check("split_ge", {31'h0, CondEx}, 32'h1);
        Cond = 4'b1011; #1;
        check("split_lt", {31'h0, CondEx}, 32'h0);
        Cond = 4'b1100; #1;
        check("split_gt", {31'h0, CondEx}, 32'h1);

        // Gating with a failed condition
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b11;
        tick;
        check("gate_clear", {28'h0, Flags}, 32'h0);
        Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        FlagW = 2'b11; ALUFlags = 4'b1111; #1;
        check("gate_condex", {31'h0, CondEx}, 32'h0);
        check("gate_regw", {31'h0, RegWrite}, 32'h0);
        check("gate_memw", {31'h0, MemWrite}, 32'h0);
        check("gate_pcsrc", {31'h0, PCSrc}, 32'h0);
        tick;
        check("gate_flags_hold", {28'h0, Flags}, 32'h0);
        check("gate_valid", {31'h0, ALUOutValid}, 32'h0);
        FlagW = 2'b00; NoWrite = 1'b1; Cond = 4'b1110; #1;
        check("nowr_regw", {31'h0, RegWrite}, 32'h0);
        check("nowr_memw", {31'h0, MemWrite}, 32'h1);
        check("nowr_pcsrc", {31'h0, PCSrc}, 32'h1);
        NoWrite = 1'b0; #1;
        check("pass_regw", {31'h0, RegWrite}, 32'h1);
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

        // Pipeline, stall, flush
        ALUResult = 32'h00000009; Cond = 4'b1110;
        tick;
        check("pipe_out", ALUOut, 32'h9);
        check("pipe_valid", {31'h0, ALUOutValid}, 32'h1);
        Stall = 1'b1; ALUResult = 32'hFFFFFFFF; FlagW = 2'b11; ALUFlags = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_out", ALUOut, 32'h9);
            check("stall_valid", {31'h0, ALUOutValid}, 32'h1);
            check("stall_flags", {28'h0, Flags}, 32'h0);
        end
        check("stall_comb_regw_off", {31'h0, RegWrite}, 32'h0);
        Flush = 1'b1;
        tick;
        check("sf_valid", {31'h0, ALUOutValid}, 32'h0);
        check("sf_out", ALUOut, 32'h9);
        check("sf_flags", {28'h0, Flags}, 32'h0);
        Stall = 1'b0; Flush = 1'b0; FlagW = 2'b00;
        tick;
        check("resume_out", ALUOut, 32'hFFFFFFFF);
        check("resume_valid", {31'h0, ALUOutValid}, 32'h1);
        Flush = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100; ALUResult = 32'h12345678;
        tick;
        check("flush_valid", {31'h0, ALUOutValid}, 32'h0);
        check("flush_out", ALUOut, 32'hFFFFFFFF);
        check("flush_flags", {28'h0, Flags}, 32'h4);
        Flush = 1'b0; FlagW = 2'b00;

        // Reset mid-stall, between edges
        Stall = 1'b1;
        tick;
        #20 reset = 1'b1;
        #1;
        check("arst_flags", {28'h0, Flags}, 32'h0);
        check("arst_out", ALUOut, 32'h0);
        check("arst_valid", {31'h0, ALUOutValid}, 32'h0);
        Cond = 4'b0001; #1;
        check("arst_ne", {31'h0, CondEx}, 32'h1);
        tick;
        #20 reset = 1'b0;
        Stall = 1'b0; ALUResult = 32'h00000005; Cond = 4'b1110;
        tick;
        check("post_rst_out", ALUOut, 32'h5);
        check("post_rst_valid", {31'h0, ALUOutValid}, 32'h1);

        // All 16 flag values x 16 condition codes
        for (int f = 0; f < 16; f++) begin
            Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f[3:0];
            tick;
            FlagW = 2'b00;
            check("sweep_flags", {28'h0, Flags}, f);
            for (int c = 0; c < 16; c++) begin
                Cond = c[3:0]; #1;
                check($sformatf("sweep_f%0h_c%0h", f, c), {31'h0, CondEx},
                      {31'h0, cond_model(c[3:0], f[3:0])});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
